// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared definitions for the RV32I multi-cycle control sequencer.
// Holds the 3-bit state encoding, base opcode constants, the instruction class
// indices used by the decoder, and the writeback / next-PC select codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bit positions inside the one-hot class vector.
  localparam int CL_LUI      = 0;
  localparam int CL_AUIPC    = 1;
  localparam int CL_JAL      = 2;
  localparam int CL_JALR     = 3;
  localparam int CL_BRANCH   = 4;
  localparam int CL_LOAD     = 5;
  localparam int CL_STORE    = 6;
  localparam int CL_OP_IMM   = 7;
  localparam int CL_OP       = 8;
  localparam int CL_FENCE    = 9;
  localparam int CL_SYSTEM   = 10;
  localparam int NUM_CLASSES = 11;

  typedef logic [NUM_CLASSES-1:0] class_vec_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

endpackage

// File: rtl/insn_class_decoder.sv
// insn_class_decoder: purely combinational instruction classifier.
// Ports: insn (32-bit instruction) -> cls (one-hot class), illegal (no class
// matched), sub_sra (ALU subtract / arithmetic-shift / compare control).
module insn_class_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output class_vec_t  cls,
  output logic        illegal,
  output logic        sub_sra
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       slt_like;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI:    cls[CL_LUI]    = 1'b1;
      OPC_AUIPC:  cls[CL_AUIPC]  = 1'b1;
      OPC_JAL:    cls[CL_JAL]    = 1'b1;
      OPC_JALR:   cls[CL_JALR]   = 1'b1;
      OPC_BRANCH: cls[CL_BRANCH] = 1'b1;
      OPC_LOAD:   cls[CL_LOAD]   = 1'b1;
      OPC_STORE:  cls[CL_STORE]  = 1'b1;
      OPC_OP_IMM: cls[CL_OP_IMM] = 1'b1;
      OPC_OP:     cls[CL_OP]     = 1'b1;
      OPC_FENCE:  cls[CL_FENCE]  = 1'b1;
      OPC_SYSTEM: cls[CL_SYSTEM] = 1'b1;
      default:    cls            = '0;
    endcase
  end

  assign illegal = (cls == '0);

  // SLT/SLTU (and SLTI/SLTIU) need the subtractor for the compare.
  assign slt_like = (funct3 == 3'b010) || (funct3 == 3'b011);

  // On OP-IMM, bit 30 is immediate data except for the shift-right group,
  // so it only selects SRAI vs SRLI there.
  always_comb begin
    sub_sra = 1'b0;
    if (cls[CL_OP])
      sub_sra = insn[30] | slt_like;
    else if (cls[CL_OP_IMM])
      sub_sra = (funct3 == 3'b101) ? insn[30] : slt_like;
    else if (cls[CL_BRANCH])
      sub_sra = 1'b1;
  end

  logic unused_insn_bits;
  assign unused_insn_bits = ^{insn[31], insn[29:15], insn[11:7]};

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I multi-cycle control sequencer
// (FETCH/DECODE/EXECUTE/MEM/WRITEBACK, TRAP on illegal opcode).
// Ports: clk, reset (sync, active-high); insn, mem_ready, branch_taken in;
// memory handshake, PC/IR/regfile enables, mux selects, sub_sra, halt, state_o out.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        sub_sra,
  output logic        halt,
  output logic [2:0]  state_o
);

  state_t     state;
  state_t     next_state;
  logic       br_flag;
  class_vec_t cls;
  logic       illegal;
  logic       dec_sub_sra;

  insn_class_decoder u_dec (
    .insn    (insn),
    .cls     (cls),
    .illegal (illegal),
    .sub_sra (dec_sub_sra)
  );

  // The branch outcome is only meaningful in EXECUTE; freezing it here makes
  // later wiggles on branch_taken harmless for the WRITEBACK PC select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      br_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (state == EXECUTE)
        br_flag <= branch_taken;
    end
  end

  always_comb begin
    next_state   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    sub_sra      = 1'b0;
    halt         = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        next_state = illegal ? TRAP : EXECUTE;
      end
      EXECUTE: begin
        // The datapath captures the ALU result at the end of this cycle,
        // so the operand selects only need to be valid here.
        alu_a_sel  = cls[CL_AUIPC] | cls[CL_JAL] | cls[CL_BRANCH];
        alu_b_sel  = ~cls[CL_OP];
        sub_sra    = dec_sub_sra;
        next_state = (cls[CL_LOAD] | cls[CL_STORE]) ? MEM : WRITEBACK;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls[CL_STORE];
        if (mem_ready)
          next_state = WRITEBACK;
      end
      WRITEBACK: begin
        pc_write  = 1'b1;
        reg_write = ~(cls[CL_STORE] | cls[CL_BRANCH] | cls[CL_FENCE] | cls[CL_SYSTEM]);
        if (cls[CL_LUI])
          wb_sel = WB_IMM;
        else if (cls[CL_JAL] | cls[CL_JALR])
          wb_sel = WB_PC4;
        else if (cls[CL_LOAD])
          wb_sel = WB_MEM;
        if (cls[CL_JAL] | cls[CL_JALR] | (cls[CL_BRANCH] & br_flag))
          pc_sel = PC_ALU;
        next_state = FETCH;
      end
      TRAP: begin
        halt = 1'b1;
      end
      default: begin
        // Unused encodings are treated as a fault and parked in TRAP.
        next_state = TRAP;
      end
    endcase

    // Reset wins over everything: no request, no architectural write and no
    // halt while it is held, independent of the state being left.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_PLUS4;
      reg_write    = 1'b0;
      wb_sel       = WB_ALU;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      sub_sra      = 1'b0;
      halt         = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed scoreboard bench for the control sequencer.
// Each step drives inputs, queues the expected output vector, and checks it mid-cycle.
// Output vector: {mem_req,mem_we,mem_addr_sel,ir_load,pc_write,pc_sel,reg_write,wb_sel,a_sel,b_sel,sub_sra,halt,state}.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel, reg_write;
  logic [1:0]  wb_sel;
  logic        alu_a_sel, alu_b_sel, sub_sra, halt;
  logic [2:0]  state_o;
  logic [15:0] obs;

  multicycle_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .insn         (insn),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .sub_sra      (sub_sra),
    .halt         (halt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel, reg_write,
                wb_sel, alu_a_sel, alu_b_sel, sub_sra, halt, state_o};

  localparam logic [15:0] MREQ = 16'h8000, MWE = 16'h4000, MAS = 16'h2000, IRL = 16'h1000;
  localparam logic [15:0] PCW = 16'h0800, PCS = 16'h0400, RW = 16'h0200;
  localparam logic [15:0] WBM = 16'h0080, WBP = 16'h0100, WBI = 16'h0180;
  localparam logic [15:0] ASEL = 16'h0040, BSEL = 16'h0020, SS = 16'h0010, HALT = 16'h0008;
  localparam logic [15:0] SF = 16'd0, SD = 16'd1, SE = 16'd2, SM = 16'd3, SW = 16'd4, ST = 16'd5;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // One clock cycle: apply inputs, queue the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic rdy, input logic bt, input logic [15:0] e);
    sb_t item;
    mem_ready    = rdy;
    branch_taken = bt;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(negedge clk);
    item = sb.pop_front();
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
    end
    @(posedge clk);
    #1;
  endtask

  // One clock cycle with no comparison.
  task automatic tick(input logic rdy, input logic bt);
    mem_ready    = rdy;
    branch_taken = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_state", 1, 0, SF);
    reset = 1'b0;

    // ADD x3,x1,x2 with one FETCH wait cycle first
    insn = 32'h002081B3;
    cyc("add_fetch_wait", 0, 0, MREQ | SF);
    cyc("add_fetch",      1, 0, MREQ | IRL | SF);
    cyc("add_decode",     0, 0, SD);
    cyc("add_execute",    0, 0, SE);
    cyc("add_wb",         0, 0, PCW | RW | SW);

    // SUB
    insn = 32'h402081B3;
    cyc("sub_fetch",   1, 0, MREQ | IRL | SF);
    cyc("sub_decode",  0, 0, SD);
    cyc("sub_execute", 0, 0, SS | SE);
    cyc("sub_wb",      0, 0, PCW | RW | SW);

    // SLTI x3,x1,5
    insn = 32'h0050A193;
    cyc("slti_fetch",   1, 0, MREQ | IRL | SF);
    cyc("slti_decode",  0, 0, SD);
    cyc("slti_execute", 0, 0, BSEL | SS | SE);
    cyc("slti_wb",      0, 0, PCW | RW | SW);

    // SRAI x3,x1,3
    insn = 32'h4030D193;
    cyc("srai_fetch",   1, 0, MREQ | IRL | SF);
    cyc("srai_decode",  0, 0, SD);
    cyc("srai_execute", 0, 0, BSEL | SS | SE);
    cyc("srai_wb",      0, 0, PCW | RW | SW);

    // ADDI x3,x1,0x400: bit 30 is immediate data, not a subtract
    insn = 32'h40008193;
    cyc("addi_fetch",   1, 0, MREQ | IRL | SF);
    cyc("addi_decode",  0, 0, SD);
    cyc("addi_execute", 0, 0, BSEL | SE);
    cyc("addi_wb",      0, 0, PCW | RW | SW);

    // LW x3,0(x1) with three MEM wait cycles: 8 cycles total
    insn = 32'h0000A183;
    cyc("lw_fetch",   1, 0, MREQ | IRL | SF);
    cyc("lw_decode",  0, 0, SD);
    cyc("lw_execute", 0, 0, BSEL | SE);
    cyc("lw_mem_w1",  0, 0, MREQ | MAS | SM);
    cyc("lw_mem_w2",  0, 0, MREQ | MAS | SM);
    cyc("lw_mem_w3",  0, 0, MREQ | MAS | SM);
    cyc("lw_mem_rdy", 1, 0, MREQ | MAS | SM);
    cyc("lw_wb",      0, 0, PCW | RW | WBM | SW);

    // SW x2,0(x1), zero-wait
    insn = 32'h0020A023;
    cyc("sw_fetch",   1, 0, MREQ | IRL | SF);
    cyc("sw_decode",  0, 0, SD);
    cyc("sw_execute", 0, 0, BSEL | SE);
    cyc("sw_mem",     1, 0, MREQ | MWE | MAS | SM);
    cyc("sw_wb",      0, 0, PCW | SW);

    // BEQ taken; branch_taken drops in WRITEBACK, mem_ready noise ignored
    insn = 32'h00208463;
    cyc("beqt_fetch",   1, 0, MREQ | IRL | SF);
    cyc("beqt_decode",  1, 0, SD);
    cyc("beqt_execute", 1, 1, ASEL | BSEL | SS | SE);
    cyc("beqt_wb",      1, 0, PCW | PCS | SW);

    // BEQ not taken; branch_taken rises in WRITEBACK
    cyc("beqn_fetch",   1, 0, MREQ | IRL | SF);
    cyc("beqn_decode",  0, 1, SD);
    cyc("beqn_execute", 0, 0, ASEL | BSEL | SS | SE);
    cyc("beqn_wb",      0, 1, PCW | SW);

    // JAL x1,16
    insn = 32'h010000EF;
    cyc("jal_fetch",   1, 0, MREQ | IRL | SF);
    cyc("jal_decode",  0, 0, SD);
    cyc("jal_execute", 0, 0, ASEL | BSEL | SE);
    cyc("jal_wb",      0, 0, PCW | PCS | RW | WBP | SW);

    // LUI x3,1
    insn = 32'h000011B7;
    cyc("lui_fetch",   1, 0, MREQ | IRL | SF);
    cyc("lui_decode",  0, 0, SD);
    cyc("lui_execute", 0, 0, BSEL | SE);
    cyc("lui_wb",      0, 0, PCW | RW | WBI | SW);

    // ECALL: no-op that only advances the PC
    insn = 32'h00000073;
    cyc("ecall_fetch",   1, 0, MREQ | IRL | SF);
    cyc("ecall_decode",  0, 0, SD);
    cyc("ecall_execute", 0, 0, BSEL | SE);
    cyc("ecall_wb",      0, 0, PCW | SW);

    // Reset during a FETCH wait
    insn = 32'h002081B3;
    cyc("rstf_wait", 0, 0, MREQ | SF);
    reset = 1'b1;
    tick(0, 0);
    cyc("rstf_held", 1, 0, SF);
    reset = 1'b0;
    cyc("rstf_resume", 0, 0, MREQ | SF);
    cyc("rstf_fetch",  1, 0, MREQ | IRL | SF);
    cyc("rstw_decode", 0, 0, SD);
    cyc("rstw_execute", 0, 0, SE);
    // Reset asserted in WRITEBACK: no PC or register write in that cycle
    reset = 1'b1;
    cyc("rstw_wb_blocked", 0, 0, SW);
    reset = 1'b0;
    cyc("rstw_after", 0, 0, MREQ | SF);

    // Illegal opcode 0x7F: TRAP at cycle 3, sticky, no requests
    insn = 32'h0000007F;
    cyc("ill_fetch",  1, 0, MREQ | IRL | SF);
    cyc("ill_decode", 1, 0, SD);
    cyc("trap_c3",    1, 0, HALT | ST);
    cyc("trap_c4",    1, 1, HALT | ST);
    insn = 32'h002081B3;
    cyc("trap_c5",    1, 0, HALT | ST);

    // Only reset leaves TRAP
    reset = 1'b1;
    tick(1, 0);
    cyc("trap_rst_held", 1, 0, SF);
    reset = 1'b0;
    cyc("trap_rst_resume", 0, 0, MREQ | SF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
